fifo_drain_scheduler: RTL and testbench
=======================================

Name: fifo_drain_scheduler

Overview:
Read-side controller for the sorter's two output FIFOs: the val FIFO (words matching the key) and the ival FIFO (non-matching words). It issues read enables to both FIFOs and arbitrates them round-robin with a burst limit. It delivers one word at a time on a single valid/ready output stream, tagged with its source, and keeps per-source drain counts. It sits between the FIFOs' read ports and the future AXI4-Lite read channel.

Parameters:
WIDTH, 32, data word width (matches FIFO word width)
DEPTH, 10, width of the FIFO occupancy and drain counters
BURST, 4, maximum consecutive grants to one source while the other source is non-empty (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
drain_en  in  1  1 = scheduler may start new FIFO reads
val_empty  in  1  val FIFO empty flag
val_rd_data  in  WIDTH  val FIFO read data, valid the cycle after val_rd_en
val_rd_en  out  1  val FIFO read strobe, one-cycle pulse
ival_empty  in  1  ival FIFO empty flag
ival_rd_data  in  WIDTH  ival FIFO read data, valid the cycle after ival_rd_en
ival_rd_en  out  1  ival FIFO read strobe, one-cycle pulse
out_valid  out  1  out_data/out_src hold a word
out_ready  in  1  consumer accepts the word when out_valid && out_ready
out_data  out  WIDTH  drained word
out_src  out  1  0 = from val, 1 = from ival
val_drained  out  DEPTH  words delivered from val, wraps modulo 2^DEPTH
ival_drained  out  DEPTH  words delivered from ival, wraps modulo 2^DEPTH
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; both rd_en=0; out_valid=0; out_data=0; out_src=0; both counts 0; busy=0; last_src=ival, so val wins the first tie; burst count 0.
- A source is eligible when its empty flag is 0. The decision samples the empty flags in the deciding cycle.
- FSM states: IDLE, RD, CAP, VALID. All outputs are registered or Moore.
- IDLE: if drain_en=1 and any source is eligible, pick the grant -> RD. Otherwise stay in IDLE.
- RD: assert rd_en of the granted source only, for exactly one cycle -> CAP.
- CAP: on the clock edge, out_data <= granted rd_data, out_src <= grant, out_valid <= 1 -> VALID.
- VALID: hold out_data and out_src stable while out_ready=0. On out_valid && out_ready:
  - out_valid <= 0 and the granted source's count is incremented.
  - If drain_en=1 and a source is eligible, re-arbitrate -> RD.
  - Otherwise -> IDLE.
- Latency: from the decision edge to out_valid is 3 cycles. Peak throughput is 1 word per 3 cycles with out_ready tied to 1.
- Arbitration, evaluated once per grant:
  - Only one source eligible: grant it, no burst limit.
  - Both eligible: keep the previous source while burst count < BURST, otherwise switch to the other source.
  - Burst count resets to 1 on a source switch and increments on a repeat grant.
- drain_en=0 mid-transfer: a word already in RD, CAP or VALID completes normally, then the FSM goes to IDLE. No new read is issued.
- The FSM never asserts both rd_en in one cycle and never asserts rd_en on a source whose empty flag is 1. The FIFOs have no other reader, so empty cannot rise between the decision and RD.
- Reset asserted mid-operation: immediate return to reset values. The FIFO word read during RD/CAP is discarded; the FIFO accounts for it.
- Counter overflow: wraps from 2^DEPTH-1 to 0, with no flag.

Decomposition:
- Shared package sorter_pkg holds:
  - FSM state encoding: ST_IDLE, ST_RD, ST_CAP, ST_VALID (2 bits).
  - SRC_VAL=1'b0 and SRC_IVAL=1'b1.
  - Default WIDTH and DEPTH constants.
- One sub-module, rr_burst_arbiter: inputs req[1:0], advance, BURST parameter; outputs grant and burst state. Reused later for AXI read/write channel arbitration.

Test Plan:
- Reset and idle: hold rst=0 for 2 cycles, then release with both empty=1 and drain_en=1 -> all outputs 0, busy=0, rd_en never asserted.
- Single word: val holds 0xA5000000, ival empty, out_ready=1 -> val_rd_en pulses one cycle; 3 cycles after the decision, out_valid=1 with out_data=0xA5000000 and out_src=0; val_drained=1.
- Backpressure: ival holds 0xA6000000, out_ready=0 for 5 cycles -> out_valid stays 1 and out_data stays stable; no further rd_en; on out_ready=1, ival_drained=1.
- Burst round-robin: BURST=4, val holds 6 words, ival holds 6 words, ready=1 -> grant sequence V,V,V,V,I,I,I,I,V,V,I,I; final counts 6/6.
- drain_en drop: deassert drain_en during CAP -> the current word is delivered, then IDLE with no further rd_en despite non-empty FIFOs; reassert -> draining resumes.
- Mid-operation reset and wrap: rst=0 during VALID -> out_valid=0 asynchronously, counts 0. With DEPTH=3, drain 9 val words -> val_drained=1.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter read-side blocks: FSM encoding, source tags
// and default widths.
package sorter_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 10;
    localparam int BURST_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_CAP   = 2'd2,
        ST_VALID = 2'd3
    } state_e;

    localparam logic SRC_VAL  = 1'b0;
    localparam logic SRC_IVAL = 1'b1;

endpackage

// File: rtl/rr_burst_arbiter.sv
// Two-requester round-robin arbiter with a burst limit. The grant is combinational
// from req; the owner and burst count advance only when the client commits a grant.
module rr_burst_arbiter
    import sorter_pkg::*;
#(
    parameter int BURST = BURST_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant,
    output logic       last_src
);

    logic       last_q, last_d;
    logic [3:0] burst_q, burst_d;

    // A zero burst count means no grant has happened yet, so a tie goes to the
    // source opposite last_q (val after reset).
    always_comb begin
        grant = last_q;
        if (req == 2'b01) begin
            grant = SRC_VAL;
        end else if (req == 2'b10) begin
            grant = SRC_IVAL;
        end else if (req == 2'b11) begin
            grant = (burst_q != 4'd0 && burst_q < 4'(BURST)) ? last_q : ~last_q;
        end
    end

    always_comb begin
        last_d  = last_q;
        burst_d = burst_q;
        if (advance) begin
            if (grant == last_q && burst_q != 4'd0) begin
                burst_d = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
            end else begin
                burst_d = 4'd1;
                last_d  = grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q  <= SRC_IVAL;
            burst_q <= 4'd0;
        end else begin
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    assign last_src = last_q;

endmodule

// File: rtl/fifo_drain_scheduler.sv
// Drains the val and ival FIFOs one word at a time onto a single valid/ready
// stream tagged with its source, keeping per-source delivered-word counts.
//   state    | meaning
//   ST_IDLE  | waiting for drain_en and a non-empty FIFO
//   ST_RD    | read strobe on the granted FIFO
//   ST_CAP   | FIFO read data captured into out_data
//   ST_VALID | word presented, waiting for out_ready
module fifo_drain_scheduler
    import sorter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drain_en,
    input  logic             val_empty,
    input  logic [WIDTH-1:0] val_rd_data,
    output logic             val_rd_en,
    input  logic             ival_empty,
    input  logic [WIDTH-1:0] ival_rd_data,
    output logic             ival_rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic [DEPTH-1:0] val_drained,
    output logic [DEPTH-1:0] ival_drained,
    output logic             busy
);

    localparam logic [DEPTH-1:0] CNT_ONE = DEPTH'(1);

    state_e           state_q, state_d;
    logic             val_rd_en_q, val_rd_en_d;
    logic             ival_rd_en_q, ival_rd_en_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic [DEPTH-1:0] val_cnt_q, val_cnt_d;
    logic [DEPTH-1:0] ival_cnt_q, ival_cnt_d;
    logic             busy_q, busy_d;

    logic [1:0] req;
    logic       start_ok;
    logic       launch;
    logic       arb_grant;
    logic       cur_src;

    assign req      = {~ival_empty, ~val_empty};
    assign start_ok = drain_en && (req != 2'b00);

    // The arbiter's owner register doubles as the grant of the word in flight.
    rr_burst_arbiter #(.BURST(BURST)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .advance  (launch),
        .grant    (arb_grant),
        .last_src (cur_src)
    );

    always_comb begin
        state_d      = state_q;
        val_rd_en_d  = 1'b0;
        ival_rd_en_d = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        val_cnt_d    = val_cnt_q;
        ival_cnt_d   = ival_cnt_q;
        launch       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                launch = start_ok;
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                out_data_d  = (cur_src == SRC_IVAL) ? ival_rd_data : val_rd_data;
                out_src_d   = cur_src;
                out_valid_d = 1'b1;
                state_d     = ST_VALID;
            end
            ST_VALID: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (cur_src == SRC_IVAL) begin
                        ival_cnt_d = ival_cnt_q + CNT_ONE;
                    end else begin
                        val_cnt_d = val_cnt_q + CNT_ONE;
                    end
                    launch  = start_ok;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            state_d      = ST_RD;
            val_rd_en_d  = (arb_grant == SRC_VAL);
            ival_rd_en_d = (arb_grant == SRC_IVAL);
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            val_rd_en_q  <= 1'b0;
            ival_rd_en_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= SRC_VAL;
            val_cnt_q    <= '0;
            ival_cnt_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            val_rd_en_q  <= val_rd_en_d;
            ival_rd_en_q <= ival_rd_en_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            val_cnt_q    <= val_cnt_d;
            ival_cnt_q   <= ival_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign val_rd_en    = val_rd_en_q;
    assign ival_rd_en   = ival_rd_en_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_src      = out_src_q;
    assign val_drained  = val_cnt_q;
    assign ival_drained = ival_cnt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Scoreboard bench for fifo_drain_scheduler: behavioural FIFOs feed the DUT and
// every delivered word is checked against the queue of expected words.
module tb_fifo_drain_scheduler;

    localparam int WIDTH = 32;
    localparam int DEPTH = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             drain_en = 1'b0;
    logic             out_ready = 1'b0;
    logic             val_empty = 1'b1;
    logic             ival_empty = 1'b1;
    logic [WIDTH-1:0] val_rd_data = '0;
    logic [WIDTH-1:0] ival_rd_data = '0;

    logic             val_rd_en, ival_rd_en, out_valid, out_src, busy;
    logic [WIDTH-1:0] out_data;
    logic [DEPTH-1:0] val_drained, ival_drained;

    logic             o3_val_rd_en, o3_ival_rd_en, o3_out_valid, o3_out_src, o3_busy;
    logic [WIDTH-1:0] o3_out_data;
    logic [2:0]       o3_val_drained, o3_ival_drained;

    typedef struct {
        logic             src;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic [WIDTH-1:0] vq[$];
    logic [WIDTH-1:0] iq[$];
    exp_t             expq[$];
    exp_t             e_mon;

    int total = 0;
    int bad = 0;
    int rd_pulses = 0;
    int exp_vcnt = 0;
    int exp_icnt = 0;

    fifo_drain_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(4)) dut (
        .clk(clk), .rst(rst), .drain_en(drain_en),
        .val_empty(val_empty), .val_rd_data(val_rd_data), .val_rd_en(val_rd_en),
        .ival_empty(ival_empty), .ival_rd_data(ival_rd_data), .ival_rd_en(ival_rd_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
        .val_drained(val_drained), .ival_drained(ival_drained), .busy(busy)
    );

    // Narrow-counter twin sharing every input; used for the wrap check.
    fifo_drain_scheduler #(.WIDTH(WIDTH), .DEPTH(3), .BURST(4)) dut3 (
        .clk(clk), .rst(rst), .drain_en(drain_en),
        .val_empty(val_empty), .val_rd_data(val_rd_data), .val_rd_en(o3_val_rd_en),
        .ival_empty(ival_empty), .ival_rd_data(ival_rd_data), .ival_rd_en(o3_ival_rd_en),
        .out_valid(o3_out_valid), .out_ready(out_ready), .out_data(o3_out_data), .out_src(o3_out_src),
        .val_drained(o3_val_drained), .ival_drained(o3_ival_drained), .busy(o3_busy)
    );

    always #5 clk = ~clk;

    // FIFO model and output scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        if (val_rd_en || ival_rd_en) begin
            rd_pulses++;
            total++;
            if (val_rd_en && ival_rd_en) begin
                bad++;
                $display("FAIL rd_en_both: val_rd_en=1 ival_rd_en=1, required at most one");
            end else if (val_rd_en) begin
                if (vq.size() == 0) begin
                    bad++;
                    $display("FAIL val_rd_on_empty: val_rd_en=1 with empty val FIFO, required 0");
                end else begin
                    val_rd_data = vq.pop_front();
                    val_empty = (vq.size() == 0);
                end
            end else begin
                if (iq.size() == 0) begin
                    bad++;
                    $display("FAIL ival_rd_on_empty: ival_rd_en=1 with empty ival FIFO, required 0");
                end else begin
                    ival_rd_data = iq.pop_front();
                    ival_empty = (iq.size() == 0);
                end
            end
        end
        if (out_valid && out_ready) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got src=%0b data=%h, required no word", out_src, out_data);
            end else begin
                e_mon = expq.pop_front();
                if (out_data !== e_mon.data || out_src !== e_mon.src) begin
                    bad++;
                    $display("FAIL word: got src=%0b data=%h, required src=%0b data=%h",
                             out_src, out_data, e_mon.src, e_mon.data);
                end
                if (e_mon.src) exp_icnt++;
                else exp_vcnt++;
            end
        end
    end

    task automatic push_word(input logic src, input logic [WIDTH-1:0] d, input logic expect_it);
        exp_t e;
        if (src) begin
            iq.push_back(d);
            ival_empty = 1'b0;
        end else begin
            vq.push_back(d);
            val_empty = 1'b0;
        end
        if (expect_it) begin
            e.src = src;
            e.data = d;
            expq.push_back(e);
        end
    endtask

    task automatic expect_word(input logic src, input logic [WIDTH-1:0] d);
        exp_t e;
        e.src = src;
        e.data = d;
        expq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy !== 1'b0 || expq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s_timeout: busy=%0b pending=%0d after %0d cycles, required idle",
                     name, busy, expq.size(), n);
        end
    endtask

    task automatic wait_out_valid(input int budget, input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s_valid_timeout: out_valid=%0b, required 1", name, out_valid);
        end
    endtask

    task automatic apply_reset();
        step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        expq.delete();
        exp_vcnt = 0;
        exp_icnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drain_en = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        total++;
        if ({out_valid, out_src, busy, val_rd_en, ival_rd_en} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b, required 00000", {out_valid, out_src, busy, val_rd_en, ival_rd_en});
        end
        total++;
        if (out_data !== '0 || val_drained !== '0 || ival_drained !== '0) begin
            bad++;
            $display("FAIL reset_values: data=%h val=%0d ival=%0d, required 0/0/0", out_data, val_drained, ival_drained);
        end
        total++;
        if ({o3_out_valid, o3_busy, o3_val_drained, o3_ival_drained} !== 8'b0) begin
            bad++;
            $display("FAIL reset_dut3: got %b, required 0", {o3_out_valid, o3_busy, o3_val_drained, o3_ival_drained});
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || rd_pulses != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_empty: busy=%0b rd_pulses=%0d out_valid=%0b, required 0/0/0", busy, rd_pulses, out_valid);
        end
    endtask

    task automatic test_single();
        int n = 0;
        int lat = 0;
        int p0 = rd_pulses;
        step();
        push_word(1'b0, 32'hA500_0000, 1'b1);
        while (val_rd_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL single_rd_timeout: val_rd_en=%0b, required 1", val_rd_en);
        end
        // RD and CAP follow the deciding cycle; out_valid shows in the third.
        while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != 2) begin
            bad++;
            $display("FAIL single_latency: %0d cycles after RD, required 2", lat);
        end
        wait_idle(50, "single");
        total++;
        if (val_drained !== 10'd1 || ival_drained !== 10'd0 || rd_pulses != p0 + 1) begin
            bad++;
            $display("FAIL single_counts: val=%0d ival=%0d pulses=%0d, required 1/0/%0d",
                     val_drained, ival_drained, rd_pulses, p0 + 1);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        step();
        out_ready = 1'b0;
        push_word(1'b1, 32'hA600_0000, 1'b1);
        wait_out_valid(20, "bp");
        p0 = rd_pulses;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'hA600_0000 || out_src !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold: valid=%0b data=%h src=%0b, required 1/a6000000/1", out_valid, out_data, out_src);
            end
        end
        total++;
        if (rd_pulses != p0) begin
            bad++;
            $display("FAIL bp_no_read: pulses=%0d, required %0d", rd_pulses, p0);
        end
        step();
        out_ready = 1'b1;
        wait_idle(50, "bp");
        total++;
        if (ival_drained !== 10'd1 || val_drained !== 10'd1) begin
            bad++;
            $display("FAIL bp_counts: val=%0d ival=%0d, required 1/1", val_drained, ival_drained);
        end
    endtask

    task automatic test_burst();
        logic [11:0] seq;
        int vi = 0;
        int ii = 0;
        apply_reset();
        drain_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_word(1'b0, 32'h0000_0100 + i, 1'b0);
            push_word(1'b1, 32'h0000_0200 + i, 1'b0);
        end
        // Grant order V,V,V,V,I,I,I,I,V,V,I,I (bit 11 first, 1 = ival).
        seq = 12'b0000_1111_0011;
        for (int k = 11; k >= 0; k--) begin
            if (seq[k]) begin
                expect_word(1'b1, 32'h0000_0200 + ii);
                ii++;
            end else begin
                expect_word(1'b0, 32'h0000_0100 + vi);
                vi++;
            end
        end
        drain_en = 1'b1;
        wait_idle(200, "burst");
        total++;
        if (val_drained !== 10'd6 || ival_drained !== 10'd6) begin
            bad++;
            $display("FAIL burst_counts: val=%0d ival=%0d, required 6/6", val_drained, ival_drained);
        end
    endtask

    task automatic test_drain_drop();
        int n = 0;
        int p0;
        step();
        drain_en = 1'b1;
        push_word(1'b0, 32'h0000_0300, 1'b1);
        push_word(1'b0, 32'h0000_0301, 1'b0);
        push_word(1'b0, 32'h0000_0302, 1'b0);
        while (val_rd_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL drop_rd_timeout: val_rd_en=%0b, required 1", val_rd_en);
        end
        step();
        drain_en = 1'b0;
        wait_idle(50, "drop");
        p0 = rd_pulses;
        repeat (6) @(negedge clk);
        total++;
        if (rd_pulses != p0 || busy !== 1'b0 || vq.size() != 2) begin
            bad++;
            $display("FAIL drop_stall: pulses=%0d busy=%0b left=%0d, required %0d/0/2", rd_pulses, busy, vq.size(), p0);
        end
        total++;
        if (val_drained !== 10'(exp_vcnt)) begin
            bad++;
            $display("FAIL drop_count: val=%0d, required %0d", val_drained, exp_vcnt);
        end
        step();
        expect_word(1'b0, 32'h0000_0301);
        expect_word(1'b0, 32'h0000_0302);
        drain_en = 1'b1;
        wait_idle(100, "resume");
        total++;
        if (val_drained !== 10'd9 || ival_drained !== 10'd6) begin
            bad++;
            $display("FAIL resume_counts: val=%0d ival=%0d, required 9/6", val_drained, ival_drained);
        end
    endtask

    task automatic test_reset_wrap();
        step();
        out_ready = 1'b0;
        push_word(1'b0, 32'h0000_BEEF, 1'b1);
        wait_out_valid(20, "mid_reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || o3_out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: valid=%0b valid3=%0b busy=%0b, required 0/0/0", out_valid, o3_out_valid, busy);
        end
        total++;
        if (val_drained !== '0 || ival_drained !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL async_reset_vals: val=%0d ival=%0d data=%h, required 0", val_drained, ival_drained, out_data);
        end
        expq.delete();
        exp_vcnt = 0;
        exp_icnt = 0;
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        drain_en = 1'b1;
        for (int i = 0; i < 9; i++) push_word(1'b0, 32'h0000_0400 + i, 1'b1);
        wait_idle(200, "wrap");
        total++;
        if (val_drained !== 10'd9 || o3_val_drained !== 3'd1) begin
            bad++;
            $display("FAIL wrap: val=%0d val3=%0d, required 9/1", val_drained, o3_val_drained);
        end
        total++;
        if (val_drained !== 10'(exp_vcnt) || ival_drained !== 10'(exp_icnt)) begin
            bad++;
            $display("FAIL wrap_model: val=%0d ival=%0d, required %0d/%0d", val_drained, ival_drained, exp_vcnt, exp_icnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_burst();
        test_drain_drop();
        test_reset_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
